// File: rtl/axis_frame_source.sv
// rtl/axis_frame_source.sv - AXI-Stream master replaying a preloaded frame with optional mid-frame valid gap
module axis_frame_source #(
    parameter int C_M00_AXIS_DATA_WIDTH = 64,
    parameter int NUM_PACKETS           = 13,
    parameter int DATAPOINTS            = 10,
    parameter int GAP_AFTER             = 37,
    parameter int GAP_CYCLES            = 12,
    parameter int ADDR_W                = 8
) (
    input  logic                                 clock,
    input  logic                                 areset,
    input  logic                                 cfg_wr_en,
    input  logic [ADDR_W-1:0]                    cfg_wr_addr,
    input  logic [C_M00_AXIS_DATA_WIDTH-1:0]     cfg_wr_data,
    input  logic                                 start,
    input  logic                                 auto_restart,
    input  logic                                 result_last,
    output logic [C_M00_AXIS_DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                 m00_axis_tvalid,
    output logic                                 m00_axis_tlast,
    input  logic                                 m00_axis_tready,
    output logic                                 busy,
    output logic [15:0]                          frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_GAP,
        ST_WAIT_RESULT
    } state_t;

    localparam int              TOTAL    = NUM_PACKETS * DATAPOINTS;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);
    // A gap at or beyond the frame end would never be reached, so it is treated as disabled
    localparam bit              GAP_EN   = (GAP_AFTER != 0) && (GAP_AFTER < TOTAL);
    localparam logic [ADDR_W-1:0] GAP_IDX  = ADDR_W'(GAP_EN ? GAP_AFTER - 1 : 0);
    localparam int              GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GCW-1:0]  GAP_END  = GCW'(GAP_CYCLES - 1);

    state_t                             r_state;
    logic [C_M00_AXIS_DATA_WIDTH-1:0]   r_mem [2**ADDR_W];
    logic [C_M00_AXIS_DATA_WIDTH-1:0]   r_tdata;
    logic                               r_tvalid;
    logic                               r_tlast;
    logic [ADDR_W-1:0]                  r_word;
    logic [GCW-1:0]                     r_gap_cnt;
    logic                               r_pending;
    logic [15:0]                        r_frames;

    logic                               w_hs;
    logic [ADDR_W-1:0]                  w_next_idx;
    logic                               w_gap_hit;

    assign w_hs       = r_tvalid && m00_axis_tready;
    assign w_next_idx = r_word + 1'b1;
    assign w_gap_hit  = GAP_EN && (r_word == GAP_IDX);

    // Frame memory holds its contents across reset; writes are accepted only while idle
    always_ff @(posedge clock) begin
        if (cfg_wr_en && (r_state == ST_IDLE)) begin
            r_mem[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_word    <= '0;
            r_gap_cnt <= '0;
            r_pending <= 1'b0;
            r_frames  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pending <= 1'b0;
                    if (start) begin
                        r_state  <= ST_STREAM;
                        r_tvalid <= 1'b1;
                        r_tdata  <= r_mem[0];
                        r_word   <= '0;
                        r_tlast  <= (LAST_IDX == '0);
                    end
                end
                ST_STREAM: begin
                    if (result_last) begin
                        r_pending <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_frames <= r_frames + 16'd1;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            if (auto_restart) begin
                                r_state <= ST_WAIT_RESULT;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_pending <= 1'b0;
                            end
                        end else begin
                            r_word  <= w_next_idx;
                            r_tdata <= r_mem[w_next_idx];
                            r_tlast <= (w_next_idx == LAST_IDX);
                            if (w_gap_hit) begin
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= '0;
                                r_state   <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (result_last) begin
                        r_pending <= 1'b1;
                    end
                    if (r_gap_cnt == GAP_END) begin
                        r_tvalid <= 1'b1;
                        r_state  <= ST_STREAM;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (!auto_restart) begin
                        r_state   <= ST_IDLE;
                        r_pending <= 1'b0;
                    end else if (r_pending || result_last) begin
                        // A pulse arriving right now restarts without waiting a cycle for the flag
                        r_pending <= 1'b0;
                        r_state   <= ST_STREAM;
                        r_tvalid  <= 1'b1;
                        r_tdata   <= r_mem[0];
                        r_word    <= '0;
                        r_tlast   <= (LAST_IDX == '0);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tlast  = r_tlast;
    assign busy            = (r_state != ST_IDLE);
    assign frames_sent     = r_frames;

endmodule

// File: tb/tb_axis_frame_source.sv
// tb/tb_axis_frame_source.sv - scoreboard bench for axis_frame_source (gapped and gapless builds)
module tb_axis_frame_source;

    localparam int TOTAL  = 130;
    localparam int GAP_AT = 37;
    localparam int GAP_LEN = 12;

    logic        clock = 1'b0;
    logic        areset, cfg_wr_en, cfg_wr_en_b, start, start_b, auto_restart, result_last, tready;
    logic [7:0]  cfg_wr_addr;
    logic [63:0] cfg_wr_data;
    logic [63:0] tdata, tdata_b;
    logic [7:0]  tstrb, tstrb_b;
    logic        tvalid, tlast, busy, tvalid_b, tlast_b, busy_b;
    logic [15:0] frames, frames_b;

    typedef logic [64:0] item_t;
    item_t q[$];
    item_t qb[$];

    int  n_checks = 0;
    int  n_err = 0;
    int  hs_idx = 0, gap_low = 0, hs_idx_b = 0, gap_low_b = 0;
    int  exp_frames = 0;
    bit  tlast_seen = 0, tlast_seen_b = 0, rand_rdy = 0, prev_stall = 0;
    logic [63:0] prev_data;

    always #5 clock = ~clock;

    axis_frame_source dut (
        .clock(clock), .areset(areset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .start(start), .auto_restart(auto_restart),
        .result_last(result_last), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
        .m00_axis_tvalid(tvalid), .m00_axis_tlast(tlast), .m00_axis_tready(tready),
        .busy(busy), .frames_sent(frames)
    );

    axis_frame_source #(.GAP_AFTER(0)) dut_nogap (
        .clock(clock), .areset(areset), .cfg_wr_en(cfg_wr_en_b), .cfg_wr_addr(cfg_wr_addr),
        .cfg_wr_data(cfg_wr_data), .start(start_b), .auto_restart(1'b0),
        .result_last(1'b0), .m00_axis_tdata(tdata_b), .m00_axis_tstrb(tstrb_b),
        .m00_axis_tvalid(tvalid_b), .m00_axis_tlast(tlast_b), .m00_axis_tready(tready),
        .busy(busy_b), .frames_sent(frames_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input bit to_b);
        for (int i = 0; i < TOTAL; i++) begin
            if (to_b) qb.push_back({i == TOTAL - 1, 64'h1000 + 64'(i)});
            else      q.push_back({i == TOTAL - 1, 64'h1000 + 64'(i)});
        end
    endtask

    task automatic start_frame(input bit to_b);
        if (to_b) start_b = 1'b1; else start = 1'b1;
        push_frame(to_b);
        @(posedge clock); #1;
        start = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_result(input bit push);
        result_last = 1'b1;
        if (push) push_frame(1'b0);
        @(posedge clock); #1;
        result_last = 1'b0;
    endtask

    // Returns 1ns after the edge on which the final word was accepted
    task automatic wait_tlast(input bit sel);
        int i = 0;
        while (!(sel ? tlast_seen_b : tlast_seen) && i < 2000) begin
            @(posedge clock); i++;
        end
        #1;
        check(sel ? "tlast_timeout_b" : "tlast_timeout", 64'(sel ? tlast_seen_b : tlast_seen), 64'd1);
        tlast_seen = 0;
        tlast_seen_b = 0;
    endtask

    task automatic wait_words(input int n);
        int i = 0;
        while (hs_idx < n && i < 2000) begin
            @(posedge clock); i++;
        end
        #1;
        check("words_timeout", 64'(hs_idx >= n), 64'd1);
    endtask

    always @(posedge clock) begin
        #2;
        if (rand_rdy) tready = ($urandom_range(0, 9) >= 3);
    end

    always @(negedge clock) begin
        item_t it;
        if (areset) begin
            prev_stall = 0;
            gap_low = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(tvalid), 64'd1);
                check("stall_data", tdata, prev_data);
            end
            if (busy && !tvalid && hs_idx > 0) gap_low++;
            if (tvalid && tready) begin
                check("hs_expected", 64'(q.size() > 0), 64'd1);
                if (hs_idx > 0) check("gap_len", 64'(gap_low), (hs_idx == GAP_AT) ? 64'(GAP_LEN) : 64'd0);
                gap_low = 0;
                if (q.size() > 0) begin
                    it = q.pop_front();
                    check("data", tdata, it[63:0]);
                    check("last", 64'(tlast), 64'(it[64]));
                    hs_idx = it[64] ? 0 : hs_idx + 1;
                    if (it[64]) tlast_seen = 1;
                end
            end
            prev_stall = tvalid && !tready;
            prev_data = tdata;
        end
    end

    always @(negedge clock) begin
        item_t it;
        if (!areset) begin
            if (busy_b && !tvalid_b && hs_idx_b > 0) gap_low_b++;
            if (tvalid_b && tready) begin
                check("hs_expected_b", 64'(qb.size() > 0), 64'd1);
                if (hs_idx_b > 0) check("nogap_b", 64'(gap_low_b), 64'd0);
                gap_low_b = 0;
                if (qb.size() > 0) begin
                    it = qb.pop_front();
                    check("data_b", tdata_b, it[63:0]);
                    check("last_b", 64'(tlast_b), 64'(it[64]));
                    hs_idx_b = it[64] ? 0 : hs_idx_b + 1;
                    if (it[64]) tlast_seen_b = 1;
                end
            end
        end
    end

    initial begin
        areset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_en_b = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        start = 1'b0; start_b = 1'b0; auto_restart = 1'b0; result_last = 1'b0; tready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("tstrb", 64'(tstrb), 64'hff);
        areset = 1'b0;

        for (int i = 0; i < TOTAL; i++) begin
            cfg_wr_en = 1'b1; cfg_wr_en_b = 1'b1;
            cfg_wr_addr = 8'(i); cfg_wr_data = 64'h1000 + 64'(i);
            @(posedge clock); #1;
        end
        cfg_wr_en = 1'b0; cfg_wr_en_b = 1'b0;

        // Single frame, ready held high
        start_frame(1'b0);
        wait_tlast(1'b0);
        exp_frames++;
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_tvalid_drop", 64'(tvalid), 64'd0);
        check("t1_frames", 64'(frames), 64'(exp_frames));
        check("t1_queue", 64'(q.size()), 64'd0);

        // Random backpressure plus an ignored config write while busy
        rand_rdy = 1;
        start_frame(1'b0);
        repeat (3) @(posedge clock);
        #1;
        cfg_wr_en = 1'b1; cfg_wr_addr = 8'd5; cfg_wr_data = 64'hdead;
        @(posedge clock); #1;
        cfg_wr_en = 1'b0;
        wait_tlast(1'b0);
        rand_rdy = 0;
        tready = 1'b1;
        exp_frames++;
        check("t2_frames", 64'(frames), 64'(exp_frames));

        // Auto-restart driven by result pulses
        auto_restart = 1'b1;
        start_frame(1'b0);
        for (int f = 0; f < 3; f++) begin
            wait_tlast(1'b0);
            exp_frames++;
            if (f < 2) begin
                check("t3_wait_tvalid", 64'(tvalid), 64'd0);
                repeat (19) @(posedge clock);
                #1;
                pulse_result(1'b1);
                check("t3_restart_tvalid", 64'(tvalid), 64'd1);
                check("t3_restart_tdata", tdata, 64'h1000);
            end
        end
        check("t3_frames", 64'(frames), 64'(exp_frames));
        check("t3_waiting", 64'(busy), 64'd1);

        // Result pulse during a frame is remembered
        pulse_result(1'b1);
        wait_words(50);
        pulse_result(1'b1);
        wait_tlast(1'b0);
        exp_frames++;
        check("t4_wait_tvalid", 64'(tvalid), 64'd0);
        check("t4_wait_busy", 64'(busy), 64'd1);
        @(posedge clock); #1;
        check("t4_pending_tvalid", 64'(tvalid), 64'd1);
        check("t4_pending_tdata", tdata, 64'h1000);
        auto_restart = 1'b0;
        wait_tlast(1'b0);
        exp_frames++;
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_frames", 64'(frames), 64'(exp_frames));

        // Reset mid-frame
        start_frame(1'b0);
        wait_words(70);
        areset = 1'b1;
        #1;
        check("t5_tvalid", 64'(tvalid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_frames", 64'(frames), 64'd0);
        q.delete();
        hs_idx = 0;
        exp_frames = 0;
        repeat (2) @(posedge clock);
        #1;
        areset = 1'b0;
        start_frame(1'b0);
        wait_tlast(1'b0);
        exp_frames++;
        check("t5_frames_after", 64'(frames), 64'(exp_frames));

        // Gapless build
        start_frame(1'b1);
        wait_tlast(1'b1);
        check("t6_frames_b", 64'(frames_b), 64'd1);
        check("t6_queue_b", 64'(qb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_frame_source.md
Name: axis_frame_source

Overview:
- AXI-Stream master that feeds the inference core's 64-bit slave input with stored example frames.
- A frame is NUM_PACKETS×DATAPOINTS words, with tlast on the final word.
- Frame words are preloaded through a simple write port, then streamed on start.
- An optional valid-gap can be inserted mid-frame. In auto-restart mode the block waits for the core's result tlast and then replays the frame.

Parameters:
- C_M00_AXIS_DATA_WIDTH, 64, stream data width in bits; must be a multiple of 8.
- NUM_PACKETS, 13, packets per frame.
- DATAPOINTS, 10, words per packet.
- GAP_AFTER, 37, number of accepted words after which tvalid drops for a gap; 0 disables the gap.
- GAP_CYCLES, 12, length of the gap in clock cycles; must be ≥1.
- ADDR_W, 8, frame memory address width; 2^ADDR_W must be ≥ NUM_PACKETS×DATAPOINTS.

Ports:
- clock  in  1  single clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- cfg_wr_en  in  1  frame memory write strobe.
- cfg_wr_addr  in  ADDR_W  frame memory write address.
- cfg_wr_data  in  C_M00_AXIS_DATA_WIDTH  frame memory write data.
- start  in  1  begin a frame; sampled only in IDLE.
- auto_restart  in  1  replay the frame after each result.
- result_last  in  1  single-cycle pulse marking the core's result tlast handshake (m00 tvalid&tready&tlast).
- m00_axis_tdata  out  C_M00_AXIS_DATA_WIDTH  stream data.
- m00_axis_tstrb  out  C_M00_AXIS_DATA_WIDTH/8  byte strobes; constant all-ones.
- m00_axis_tvalid  out  1  stream valid.
- m00_axis_tlast  out  1  final word of the frame.
- m00_axis_tready  in  1  downstream ready.
- busy  out  1  high whenever state ≠ IDLE.
- frames_sent  out  16  count of completed frames; wraps at 2^16.

Behaviour:
- Definitions:
  - TOTAL = NUM_PACKETS×DATAPOINTS.
  - A handshake ("hs") is tvalid&tready on a rising clock edge.
  - States: IDLE, STREAM, GAP, WAIT_RESULT.
- Reset (areset=1, asynchronous):
  - state=IDLE; tvalid=0, tlast=0, tdata=0, busy=0, frames_sent=0.
  - Word counter, gap counter and the pending-result flag are all 0.
  - Frame memory contents are not reset.
  - Reset asserted mid-frame aborts the frame immediately; there is no tlast.
- Registers and memory:
  - tdata, tvalid and tlast are registered.
  - Memory read is asynchronous; the registered tdata is loaded from mem[index].
- cfg writes take effect only in IDLE; writes in any other state are ignored.
- IDLE:
  - start=1 at edge N → STREAM.
  - At N+1: tvalid=1, tdata=mem[0], word counter=0.
  - If TOTAL=1, tlast=1 together with word 0.
- STREAM:
  - tvalid stays high and tdata stable until hs (AXIS rule; no retraction).
  - On hs of word k<TOTAL-1, the next cycle presents mem[k+1].
  - tlast is high exactly while word TOTAL-1 is presented.
  - Gap: if GAP_AFTER≠0 and hs brings the accepted count to GAP_AFTER (<TOTAL) → GAP.
    - tvalid=0 for exactly GAP_CYCLES cycles.
    - tdata is preloaded with the next word during the gap.
    - Then back to STREAM with tvalid=1.
  - On the tlast hs:
    - frames_sent increments and tvalid drops the next cycle.
    - auto_restart=1 → WAIT_RESULT; otherwise → IDLE.
- result_last:
  - A pulse seen in STREAM, GAP or WAIT_RESULT sets the pending flag.
  - Multiple pulses collapse into one.
- WAIT_RESULT:
  - Once the pending flag is set, clear it and restart: the next cycle is word 0 in STREAM (same as leaving IDLE).
  - auto_restart deasserted while in WAIT_RESULT → IDLE on the next edge; the pending flag is cleared.
- start asserted while busy is ignored.

Test Plan:
- Load TOTAL=130 words (value = 0x1000+addr), hold tready=1, pulse start, auto_restart=0 → 130 hs with data 0x1000..0x1081.
  - tvalid low for exactly 12 cycles after the 37th hs.
  - tlast only on 0x1081.
  - frames_sent=1, back to IDLE.
- Random tready with 30% low duty → data order unchanged; tdata/tvalid never change while tvalid&!tready.
- auto_restart=1; result_last pulsed 20 cycles after the tlast hs → word 0x1000 presented on the cycle after the pulse edge.
  - Repeat 3 frames → frames_sent=3.
- result_last pulsed mid-frame (word 50) → pending latched; the next frame starts one cycle after entering WAIT_RESULT with no further pulse.
- areset pulsed at word 70 → tvalid=0 immediately.
  - After release and start, the frame restarts at 0x1000.
  - Memory contents are intact; frames_sent=0.
- cfg write to addr 5 while busy → ignored; the next frame still sends 0x1005. GAP_AFTER=0 build → no tvalid gap across a 130-word frame.
